// File: rtl/store_unit.sv
// Posted-write store path: decodes stores, buffers {MAR, MDR} in a small FIFO and drains it
// to memory with a mem_ready handshake, stalling the CPU while the buffer is full.
module store_unit #(
    parameter logic [3:0]  OPCODE_STORE = 4'h3,
    parameter int unsigned DEPTH        = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             instruction,
    input  logic                    instr_valid,
    input  logic [15:0]             MAR,
    input  logic [15:0]             MDR,
    input  logic                    mem_ready,
    output logic [15:0]             addr,
    output logic [15:0]             out_mem_data,
    output logic                    write_mem_enable,
    output logic                    is_stored,
    output logic                    stall,
    output logic [$clog2(DEPTH):0]  pending
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         is_stored_q, is_stored_d;
    logic [31:0]  entry_q [DEPTH];

    logic is_store;
    logic full;
    logic empty;
    logic do_enq;
    logic do_ret;

    logic unused_instr;
    assign unused_instr = ^instruction[11:0];

    // One extra pointer bit distinguishes full from empty when the index bits match.
    always_comb begin
        is_store = instr_valid && (instruction[15:12] == OPCODE_STORE);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_enq   = is_store && !full;
        do_ret   = !empty && mem_ready;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        is_stored_d = do_ret;
        if (do_enq) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_ret) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            is_stored_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            is_stored_q <= is_stored_d;
        end
    end

    // Entry storage is deliberately unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            entry_q[wr_ptr_q[AW-1:0]] <= {MAR, MDR};
        end
    end

    always_comb begin
        addr             = 16'h0;
        out_mem_data     = 16'h0;
        write_mem_enable = 1'b0;
        if (!empty) begin
            addr             = entry_q[rd_ptr_q[AW-1:0]][31:16];
            out_mem_data     = entry_q[rd_ptr_q[AW-1:0]][15:0];
            write_mem_enable = 1'b1;
        end
        stall     = is_store && full;
        is_stored = is_stored_q;
        pending   = wr_ptr_q - rd_ptr_q;
    end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: a queue-based model of the write buffer is compared
// against the DUT every cycle, alongside directed scenarios with literal expectations.
module tb_store_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        mem_ready;
    logic [15:0] addr;
    logic [15:0] out_mem_data;
    logic        write_mem_enable;
    logic        is_stored;
    logic        stall;
    logic [1:0]  pending;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [31:0] retired[$];
    logic [31:0] expect_list[$];
    logic        exp_stored;
    bit          chk_en = 1'b0;

    store_unit #(
        .OPCODE_STORE (4'h3),
        .DEPTH        (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instruction      (instruction),
        .instr_valid      (instr_valid),
        .MAR              (MAR),
        .MDR              (MDR),
        .mem_ready        (mem_ready),
        .addr             (addr),
        .out_mem_data     (out_mem_data),
        .write_mem_enable (write_mem_enable),
        .is_stored        (is_stored),
        .stall            (stall),
        .pending          (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of {addr, data}; one store enters and the head leaves per edge.
    function automatic bit model_step(input bit st, input bit mr, input logic [31:0] ent);
        bit en;
        bit rt;
        en = st && (mq.size() < DEPTH);
        rt = (mq.size() != 0) && mr;
        if (rt) retired.push_back(mq.pop_front());
        if (en) mq.push_back(ent);
        return rt;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_stored <= 1'b0;
        end else begin
            exp_stored <= model_step(instr_valid && instruction[15:12] == 4'h3, mem_ready,
                                     {MAR, MDR});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wme", {31'b0, write_mem_enable}, {31'b0, mq.size() != 0});
            chk("addr", {16'b0, addr}, (mq.size() != 0) ? {16'b0, mq[0][31:16]} : 32'h0);
            chk("data", {16'b0, out_mem_data}, (mq.size() != 0) ? {16'b0, mq[0][15:0]} : 32'h0);
            chk("pending", {30'b0, pending}, mq.size());
            chk("stall", {31'b0, stall},
                {31'b0, instr_valid && instruction[15:12] == 4'h3 && mq.size() == DEPTH});
            chk("is_stored", {31'b0, is_stored}, {31'b0, exp_stored});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [15:0] a, input logic [15:0] d);
        instruction = {4'h3, 12'($urandom)};
        instr_valid = 1'b1;
        MAR         = a;
        MDR         = d;
    endtask

    task automatic set_idle();
        instr_valid = 1'b0;
        instruction = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        set_idle();
        mem_ready = 1'b1;
        n = 0;
        while (mq.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk("drain_done", mq.size(), 0);
        cyc();
    endtask

    task automatic check_order(input string name);
        chk({name, "_count"}, retired.size(), expect_list.size());
        for (int k = 0; k < expect_list.size() && k < retired.size(); k++) begin
            chk(name, retired[k], expect_list[k]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = 16'h0;
        MAR         = 16'h0;
        MDR         = 16'h0;
        mem_ready   = 1'b0;
        #1;
        chk("rst_wme", {31'b0, write_mem_enable}, 0);
        chk("rst_pending", {30'b0, pending}, 0);
        chk("rst_stored", {31'b0, is_stored}, 0);
        chk_en = 1'b1;
        #22;
        rst_n = 1'b1;
        cyc();

        // Single store with memory ready.
        set_store(16'h0040, 16'hBEEF);
        mem_ready = 1'b1;
        chk("s_pending0", {30'b0, pending}, 0);
        cyc();
        set_idle();
        #1;
        chk("s_wme", {31'b0, write_mem_enable}, 1);
        chk("s_addr", {16'b0, addr}, 32'h0040);
        chk("s_data", {16'b0, out_mem_data}, 32'hBEEF);
        chk("s_pending1", {30'b0, pending}, 1);
        cyc();
        chk("s_stored", {31'b0, is_stored}, 1);
        chk("s_pending2", {30'b0, pending}, 0);
        cyc();
        chk("s_stored_off", {31'b0, is_stored}, 0);

        // Back-pressure, then full with a same-cycle retire.
        retired.delete();
        expect_list = '{32'h00A0_1111, 32'h00A1_2222, 32'h00A2_3333};
        mem_ready = 1'b0;
        set_store(16'h00A0, 16'h1111);
        cyc();
        set_store(16'h00A1, 16'h2222);
        cyc();
        chk("bp_pending", {30'b0, pending}, 2);
        set_store(16'h00A2, 16'h3333);
        #1;
        chk("bp_stall", {31'b0, stall}, 1);
        cyc();
        chk("bp_stall_hold", {31'b0, stall}, 1);
        mem_ready = 1'b1;
        cyc();
        chk("bp_stall_clear", {31'b0, stall}, 0);
        chk("bp_pending_after", {30'b0, pending}, 1);
        cyc();
        drain();
        check_order("bp_order");

        // Pointer wrap with mem_ready toggling.
        retired.delete();
        expect_list.delete();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [15:0] a;
            logic [15:0] d;
            bit acc;
            int tries;
            a = 16'($urandom);
            d = 16'($urandom);
            expect_list.push_back({a, d});
            set_store(a, d);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 20) begin
                acc = (mq.size() < DEPTH);
                cyc();
                mem_ready = ~mem_ready;
                tries++;
            end
            chk("wrap_accept", {31'b0, acc}, 1);
        end
        drain();
        chk("wrap_pending_end", {30'b0, pending}, 0);
        check_order("wrap_order");

        // Non-store filter.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            instr_valid = (i % 2 == 0);
            instruction = (i % 2 == 0) ? {4'h1, 12'($urandom)} : {4'h3, 12'($urandom)};
            MAR = 16'($urandom);
            MDR = 16'($urandom);
            #1;
            chk("nf_stall", {31'b0, stall}, 0);
            cyc();
            chk("nf_wme", {31'b0, write_mem_enable}, 0);
            chk("nf_pending", {30'b0, pending}, 0);
        end

        // Reset with two writes pending.
        mem_ready = 1'b0;
        set_store(16'h0011, 16'h0022);
        cyc();
        set_store(16'h0033, 16'h0044);
        cyc();
        set_idle();
        chk("rm_pending2", {30'b0, pending}, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_wme", {31'b0, write_mem_enable}, 0);
        chk("rm_addr", {16'b0, addr}, 0);
        chk("rm_data", {16'b0, out_mem_data}, 0);
        chk("rm_pending", {30'b0, pending}, 0);
        #6;
        rst_n = 1'b1;
        cyc();
        retired.delete();
        expect_list = '{32'h0100_00AA};
        mem_ready = 1'b1;
        set_store(16'h0100, 16'h00AA);
        cyc();
        drain();
        check_order("rm_first");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            instr_valid = 1'($urandom_range(0, 1));
            instruction = {($urandom_range(0, 3) == 0) ? 4'h5 : 4'h3, 12'($urandom)};
            MAR = 16'($urandom);
            MDR = 16'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Posted-write store path for the z0 CPU: the write-side counterpart of the load path. It decodes store instructions from the instruction register, captures the MAR/MDR pair into a small FIFO, and drains it to memory over the `addr`/`out_mem_data`/`write_mem_enable` interface with a `mem_ready` acceptance handshake. When the FIFO is full, the CPU is stalled.

## Interface

- `OPCODE_STORE`, default 4'h3: value of `instruction[15:12]` that denotes a store.
- `DEPTH`, default 2: write-buffer entries; power of two, at least 2.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `instruction` input 16: current IR contents.
- `instr_valid` input 1: IR holds a new instruction this cycle; high for exactly one accepted cycle per instruction.
- `MAR` input 16: store address.
- `MDR` input 16: store data.
- `mem_ready` input 1: memory accepts the presented write this cycle.
- `addr` output 16: write address to memory.
- `out_mem_data` output 16: write data to memory.
- `write_mem_enable` output 1: write request, i.e. the buffer is non-empty.
- `is_stored` output 1: one-cycle pulse after a write has been accepted by memory.
- `stall` output 1: store presented while the buffer is full; CPU must hold IR/MAR/MDR.
- `pending` output $clog2(DEPTH)+1: number of buffered writes, from 0 to DEPTH.

## Operation

- Store detect: `is_store = instr_valid && instruction[15:12] == OPCODE_STORE`.
- Enqueue: when `is_store && !full`, at the clock edge write {MAR, MDR} to `wr_ptr` and increment `wr_ptr`.
- `stall = is_store && full`. This is combinational and has no pass-through. Even if `mem_ready` retires an entry in the same cycle, a store presented while full is refused; the CPU retries next cycle.
- Head presentation: when the buffer is non-empty, `addr`/`out_mem_data` show the entry at `rd_ptr` and `write_mem_enable` is 1. When empty, all three are 0.
- Retire: when `write_mem_enable && mem_ready`, at the clock edge increment `rd_ptr` and set `is_stored` to 1 for the next cycle.
- `mem_ready` while empty is ignored.
- Memory may hold `mem_ready` low indefinitely. The head stays stable (same addr and data, `write_mem_enable` held high) until it is accepted.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - `full` means the MSBs differ and the remaining bits are equal.
  - `empty` means the pointers are equal.
  - `pending = wr_ptr - rd_ptr`, computed modulo 2·DEPTH.
- Simultaneous enqueue and retire (not full, not empty): both happen and `pending` is unchanged.
- Ordering is strict FIFO. Writes reach memory in program order.
- Non-store instructions, and cycles with `instr_valid` low, have no effect.
- Write-to-write with the same address: both writes are issued; there is no merging.

## Timing

- Reset (asynchronous, applies immediately):
  - pointers are 0;
  - `addr`, `out_mem_data`, `write_mem_enable`, `is_stored`, `pending` are 0;
  - `stall` follows `is_store` and is 0 because the buffer is empty.
  - Buffered writes are discarded.
  - A reset asserted while `write_mem_enable` is high drops it without waiting for the clock.
- Enqueue-to-request latency: a store accepted at edge N into an empty buffer gives `write_mem_enable` = 1 after edge N, so memory sees it in cycle N+1.
- Request-to-ack: retirement occurs at the first edge where `mem_ready` = 1; `is_stored` is high for the following cycle only.
- Back-to-back: with `mem_ready` tied high, one write retires per cycle, and sustained throughput is one store per cycle with no stalls.
- `stall` is purely combinational from `instr_valid`, `instruction`, and the registered `full`. It never depends combinationally on `mem_ready`.
- The entry storage needs no reset. Only the pointers and the `is_stored` register reset.

## Test plan

- Single store, MAR=16'h0040, MDR=16'hBEEF, `mem_ready` high: `write_mem_enable` goes high the cycle after accept with addr=0040 and data=BEEF; it retires at the next edge; `is_stored` pulses once; `pending` sequence is 0→1→0.
- Back-pressure: `mem_ready` low and 3 stores (A0/1111, A1/2222, A2/3333) with DEPTH=2:
  - the first two are accepted and `pending`=2;
  - the third sees `stall`=1 and is held;
  - raise `mem_ready`: writes appear in the order A0, A1, A2;
  - `stall` clears one cycle after the first retire.
- Full plus same-cycle retire: buffer full, `mem_ready` high, store presented: `stall`=1 that cycle, the store is accepted next cycle, and no entry is lost or duplicated.
- Pointer wrap: 10 consecutive stores with `mem_ready` toggling 1,0,1,0…: all 10 arrive in order with correct address/data pairs; `pending` never exceeds 2 and ends at 0.
- Non-store filter: `instruction[15:12]`=4'h1 with `instr_valid`=1, plus a store opcode with `instr_valid`=0: no enqueue, `write_mem_enable` stays 0, and `stall` stays 0.
- Reset mid-operation: with 2 pending and `mem_ready` low, assert `rst_n`=0 between edges:
  - `write_mem_enable`, `addr`, `out_mem_data`, and `pending` go to 0 immediately;
  - after release, a new store 16'h0100/16'h00AA is the first write issued.
